ifid_queue: RTL and testbench
=============================

IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port EN  input  1  global enable; low freezes all state.
REQ-005 SHALL have port flush  input  1  discard all entries; driven by fetch PC_Changed.
REQ-006 SHALL have port in_valid  input  1  fetch offers an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port in_pc  input  32  fetch PC_add.
REQ-009 SHALL have port in_pc_link  input  32  fetch PC_link.
REQ-010 SHALL have port in_instr  input  32  fetch instr.
REQ-011 SHALL have port out_valid  output  1  head entry present for decode.
REQ-012 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port out_pc, out_pc_link, out_instr  output  32 each  head entry fields.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL push when in_valid & in_ready; pop when out_valid & out_ready; both may occur in one cycle.
REQ-016 SHALL drive in_ready = EN & !flush & (count != DEPTH); no combinational path from out_ready to in_ready.
REQ-017 SHALL drive out_valid = EN & !flush & (count != 0).
REQ-018 SHALL present head fields combinationally from storage; when out_valid = 0, out_pc/out_pc_link/out_instr = 32'h0 (bubble).
REQ-019 SHALL have push-to-out_valid latency of 1 cycle when empty (no fall-through).
REQ-020 SHALL advance write pointer on push, read pointer on pop, each wrapping DEPTH-1 -> 0.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged on both or neither.
REQ-022 SHALL on flush = 1 (with EN = 1) set both pointers and count to 0 at next edge; flush overrides same-cycle push and pop.
REQ-023 SHALL with EN = 0 hold pointers, count and storage; flush ignored while EN = 0.
REQ-024 SHALL when full with simultaneous pop: pop only (in_ready already 0); accept again next cycle.
REQ-025 SHALL when empty: out_ready ignored, no pointer change.
REQ-026 SHALL never overwrite an occupied entry nor pop an empty queue.

Reset
REQ-027 SHALL on RSTn = 0 asynchronously clear pointers, count and all storage to 0.
REQ-028 SHALL hold outputs while in reset: count = 0, out_valid = 0, out fields = 0, in_ready = 0.
REQ-029 SHALL have no reset dependency beyond RSTn; first push accepted at the first edge after release with EN = 1.

Structure
REQ-030 SHALL define typedef ifq_entry_t {pc, pc_link, instr; 32 bits each} and constant IFQ_DEPTH = 4 in my_pkg.
REQ-031 SHALL isolate the entry array in one sub-module ifq_storage: write port (en, addr, data), async-read port, RSTn clear.
REQ-032 SHALL keep pointer/count control in ifid_queue.

Verification
REQ-033 SHALL test: reset, EN = 1, push pc 0x00, 0x04, 0x08 with instr 0x00000013 -> out_valid one cycle after first push, pops in order, count 3 -> 0.
REQ-034 SHALL test: 5 pushes with out_ready = 0 -> in_ready drops after the 4th, count = 4, the 5th is held by fetch, not lost.
REQ-035 SHALL test: full queue, push+pop same cycle -> only pop occurs, count 3; next cycle push accepted, count 4.
REQ-036 SHALL test: 3 entries, flush with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0, out_instr = 0.
REQ-037 SHALL test: EN = 0 for 3 cycles mid-stream with in_valid = out_ready = 1 -> no change in count or head; resume in order.
REQ-038 SHALL test: RSTn low mid-operation with count = 2 -> count = 0 and out_valid = 0 immediately, before the next edge.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package my_pkg;

   localparam int IFQ_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_link;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF/ID queue: one synchronous write port, one
// asynchronous read port, cleared by the asynchronous reset.
module ifq_storage
   import my_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  ifq_entry_t      wr_data,
   input  logic [AW-1:0]   rd_addr,
   output ifq_entry_t      rd_data
);

   ifq_entry_t mem [DEPTH];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: pointer and occupancy control around ifq_storage,
// with ready/valid handshakes on both sides and a flush from PC changes.
module ifid_queue
   import my_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH
) (
   input  logic                      CLK,
   input  logic                      RSTn,
   input  logic                      EN,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_pc,
   input  logic [31:0]               in_pc_link,
   input  logic [31:0]               in_instr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_pc,
   output logic [31:0]               out_pc_link,
   output logic [31:0]               out_instr,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   ifq_entry_t    wr_entry;
   ifq_entry_t    head;

   // Handshakes depend only on registered count, so out_ready never reaches in_ready.
   assign in_ready  = RSTn & EN & ~flush & (count != FULL_COUNT);
   assign out_valid = RSTn & EN & ~flush & (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign wr_entry = '{pc: in_pc, pc_link: in_pc_link, instr: in_instr};

   ifq_storage #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (EN) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   assign out_pc      = out_valid ? head.pc      : 32'h0;
   assign out_pc_link = out_valid ? head.pc_link : 32'h0;
   assign out_instr   = out_valid ? head.instr   : 32'h0;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_ifid_queue;
   import my_pkg::*;

   localparam int DEPTH = IFQ_DEPTH;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          EN;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pc;
   logic [31:0]   in_pc_link;
   logic [31:0]   in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [31:0]   out_pc_link;
   logic [31:0]   out_instr;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   ifq_entry_t model_q [$];

   ifid_queue #(.DEPTH(DEPTH)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .EN          (EN),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_pc_link  (in_pc_link),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_pc_link (out_pc_link),
      .out_instr   (out_instr),
      .count       (count)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy);
      in_valid   = v;
      in_pc      = pc;
      in_pc_link = pc + 32'h4;
      in_instr   = 32'h0000_0013;
      out_ready  = rdy;
   endtask

   // Reference model: a plain FIFO of entries following the handshake rules.
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         model_q.delete();
      end else if (EN) begin
         if (flush) begin
            model_q.delete();
         end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (model_q.size() > 0) && out_ready;
            do_push = (model_q.size() < DEPTH) && in_valid;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: in_pc, pc_link: in_pc_link, instr: in_instr});
         end
      end
   end

   // Every mid-cycle, all outputs must agree with the model.
   always @(negedge CLK) begin
      logic exp_valid;
      logic exp_ready;
      exp_valid = RSTn && EN && !flush && (model_q.size() > 0);
      exp_ready = RSTn && EN && !flush && (model_q.size() < DEPTH);
      checkOutput("model_count", 32'(count), 32'(model_q.size()));
      checkOutput("model_out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("model_in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("model_out_pc", out_pc, exp_valid ? model_q[0].pc : 32'h0);
      checkOutput("model_out_pc_link", out_pc_link, exp_valid ? model_q[0].pc_link : 32'h0);
      checkOutput("model_out_instr", out_instr, exp_valid ? model_q[0].instr : 32'h0);
   end

   initial begin
      RSTn = 1'b0;
      EN   = 1'b0;
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      step();
      step();
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_instr", out_instr, 32'h0);
      RSTn = 1'b1;
      EN   = 1'b1;

      // Three pushes, one-cycle latency, in-order pops.
      applyStimulus(1'b1, 32'h00, 1'b0);
      #1 checkOutput("no_fallthrough", 32'(out_valid), 32'd0);
      step();
      checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
      checkOutput("first_head_instr", out_instr, 32'h0000_0013);
      applyStimulus(1'b1, 32'h04, 1'b0);
      step();
      applyStimulus(1'b1, 32'h08, 1'b0);
      step();
      checkOutput("three_count", 32'(count), 32'd3);
      applyStimulus(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("pop_order_pc", out_pc, 32'(4 * i));
         step();
      end
      checkOutput("drained_count", 32'(count), 32'd0);
      checkOutput("drained_valid", 32'(out_valid), 32'd0);

      // Five pushes into a four-deep queue; the fifth is held by fetch.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0);
         checkOutput("fill_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
      end
      checkOutput("full_count", 32'(count), 32'd4);

      // Full with push and pop together: only the pop happens.
      applyStimulus(1'b1, 32'h110, 1'b1);
      step();
      checkOutput("full_pushpop_count", 32'(count), 32'd3);
      applyStimulus(1'b1, 32'h110, 1'b0);
      step();
      checkOutput("refill_count", 32'(count), 32'd4);
      applyStimulus(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("held_entry_order", out_pc, 32'h104 + 32'(4 * i));
         step();
      end

      // Flush overrides push and pop.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b0);
         step();
      end
      applyStimulus(1'b1, 32'h20c, 1'b1);
      flush = 1'b1;
      #1 checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_out_instr", out_instr, 32'h0);

      // EN low freezes everything despite active handshakes.
      applyStimulus(1'b1, 32'h300, 1'b0);
      step();
      applyStimulus(1'b1, 32'h304, 1'b0);
      step();
      applyStimulus(1'b1, 32'h308, 1'b1);
      EN = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("frozen_count", 32'(count), 32'd2);
      end
      flush = 1'b0;
      EN = 1'b1;
      #1 checkOutput("resume_head", out_pc, 32'h300);
      step();
      checkOutput("resume_count", 32'(count), 32'd2);
      checkOutput("resume_head2", out_pc, 32'h304);
      applyStimulus(1'b0, 32'h0, 1'b1);
      step();
      checkOutput("resume_head3", out_pc, 32'h308);
      step();

      // Asynchronous reset mid-operation.
      applyStimulus(1'b1, 32'h400, 1'b0);
      step();
      applyStimulus(1'b1, 32'h404, 1'b0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("pre_reset_count", 32'(count), 32'd2);
      #2 RSTn = 1'b0;
      #1;
      checkOutput("async_reset_count", 32'(count), 32'd0);
      checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
      step();
      RSTn = 1'b1;

      // Randomized traffic checked by the model.
      for (int i = 0; i < 600; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         EN         = ($urandom_range(0, 9) != 0);
         in_pc      = $urandom;
         in_pc_link = $urandom;
         in_instr   = $urandom;
         step();
      end

      applyStimulus(1'b0, 32'h0, 1'b0);
      flush = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
